fib_index_finder: RTL and testbench
===================================

Name: fib_index_finder

Overview:
Inverse of the Fibonacci generator datapath. Given a 16-bit value, it walks the Fibonacci sequence one term per cycle from F(0)=0, F(1)=1. It reports the largest index n with F(n) <= value, the term F(n), and whether the value is an exact Fibonacci number. It is used as a checker/decoder next to the generator and uses the same 5-bit index and 16-bit term widths.

Parameters:
WIDTH, 16, width of input value and term registers
IDX_W, 5, width of index output
MAX_IDX, 24, largest n with F(n) representable in WIDTH bits (F(24)=46368); only defaults are verified

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
value_in  input  WIDTH  value to decode; captured on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; results valid from this cycle on
index_out  output  IDX_W  largest n with F(n) <= value
fib_out  output  WIDTH  F(index_out)
exact  output  1  fib_out == captured value

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, index_out=0, fib_out=0, exact=0; internal registers cleared.
- Internal registers:
  - val (WIDTH): captured target.
  - k (IDX_W): current index.
  - cur (WIDTH): F(k).
  - nxt (WIDTH+1 bits): F(k+1), held 17 bits wide so F(25) cannot wrap.
- States: IDLE, SEARCH, DONE.
- IDLE: when start=1 at the edge, load val<=value_in, k<=0, cur<=0, nxt<=1, and go to SEARCH. When start=0, stay in IDLE.
- SEARCH, evaluated each cycle:
  - Stop if nxt > val (unsigned, zero-extend val) or k == MAX_IDX.
    - On stop: index_out<=k, fib_out<=cur, exact<=(cur==val), go to DONE.
  - Otherwise: cur<=nxt[WIDTH-1:0], nxt<=cur+nxt, k<=k+1.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE. Results hold until the next accepted start's DONE, or until reset.
- busy=1 in SEARCH and DONE; 0 in IDLE.
- Latency: for a start accepted at the edge ending cycle t, done is high in cycle t+index+2.
  - value 0 -> t+2.
  - value 65535 -> t+26.
- Ties: value 1 returns index 2, the largest n with F(n)=1.
- start while busy: ignored, no queuing. start in the DONE cycle is ignored; a new start is accepted in IDLE only.
- Values above 46368: search stops on k==MAX_IDX with index 24, fib_out=46368, exact=0 (exact=1 only for 46368).
- Reset mid-search: immediate return to IDLE with all outputs cleared; no done pulse.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared header: state encodings (IDLE/SEARCH/DONE), WIDTH, IDX_W, and MAX_IDX constants, also usable by the generator side.
- One sub-module, fib_step_unit: combinational. Inputs cur, nxt, val, k. Outputs next_cur, next_nxt (cur+nxt, 17 bits), and stop (nxt>val or k==MAX_IDX). The FSM and registers stay in the top module.

Test Plan:
- Reset, then start with value_in=0 -> done at t+2; index_out=0, fib_out=0, exact=1; busy high in cycles t+1..t+2.
- value_in=1 -> index_out=2, fib_out=1, exact=1, done at t+4.
- value_in=100 -> index_out=11, fib_out=89, exact=0, done at t+13. Then value_in=144 -> index_out=12, exact=1.
- value_in=46368 -> index_out=24, fib_out=46368, exact=1. value_in=65535 -> index_out=24, fib_out=46368, exact=0, done at t+26, no wrap.
- start with value_in=100, pulse start with value_in=5 during SEARCH -> ignored; result still index 11. Start issued in the DONE cycle -> ignored.
- start with value_in=1000, assert reset=0 at t+5 -> outputs 0 asynchronously, no done. After release, start with 8 -> index_out=6, exact=1.

Source files
------------

// File: rtl/fib_index_finder_pkg.sv
// rtl/fib_index_finder_pkg.sv - shared Fibonacci widths, limits and FSM encoding
// Shared with the generator side: term/index widths, last representable
// index, and the finder's state encoding.
package fib_index_finder_pkg;

  localparam int FIB_WIDTH   = 16;  // value and term width
  localparam int FIB_IDX_W   = 5;   // index width
  localparam int FIB_MAX_IDX = 24;  // F(24)=46368 is the last term that fits

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } fib_state_t;

endpackage

// File: rtl/fib_step_unit.sv
// rtl/fib_step_unit.sv - one combinational Fibonacci walk step with stop test
// Ports:
//   cur      F(k)
//   nxt      F(k+1), one bit wider than a term
//   val      captured target value
//   k        current index
//   next_cur F(k+1) truncated to a term
//   next_nxt F(k+2) = cur + nxt
//   stop     walk must end at k: next term overshoots val or k is the last index
module fib_step_unit
  import fib_index_finder_pkg::*;
#(
  parameter int WIDTH   = FIB_WIDTH,
  parameter int IDX_W   = FIB_IDX_W,
  parameter int MAX_IDX = FIB_MAX_IDX
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH:0]   nxt,
  input  logic [WIDTH-1:0] val,
  input  logic [IDX_W-1:0] k,
  output logic [WIDTH-1:0] next_cur,
  output logic [WIDTH:0]   next_nxt,
  output logic             stop
);

  assign next_cur = nxt[WIDTH-1:0];
  assign next_nxt = {1'b0, cur} + nxt;
  // nxt is compared at full width so F(25) never aliases to a small value.
  assign stop     = (nxt > {1'b0, val}) || (k == IDX_W'(MAX_IDX));

endmodule

// File: rtl/fib_index_finder.sv
// rtl/fib_index_finder.sv - finds largest n with F(n) <= value, one term per cycle
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      request, sampled only while idle
//   value_in   value to decode, captured on an accepted start
//   busy       high from the cycle after an accepted start through done
//   done       one-cycle pulse; results valid from this cycle on
//   index_out  largest n with F(n) <= value
//   fib_out    F(index_out)
//   exact      fib_out equals the captured value
module fib_index_finder
  import fib_index_finder_pkg::*;
#(
  parameter int WIDTH   = FIB_WIDTH,
  parameter int IDX_W   = FIB_IDX_W,
  parameter int MAX_IDX = FIB_MAX_IDX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value_in,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] index_out,
  output logic [WIDTH-1:0] fib_out,
  output logic             exact
);

  fib_state_t       state, state_next;
  logic [WIDTH-1:0] val;
  logic [IDX_W-1:0] k;
  logic [WIDTH-1:0] cur;
  logic [WIDTH:0]   nxt;

  logic [WIDTH-1:0] step_cur;
  logic [WIDTH:0]   step_nxt;
  logic             step_stop;

  fib_step_unit #(
    .WIDTH   (WIDTH),
    .IDX_W   (IDX_W),
    .MAX_IDX (MAX_IDX)
  ) u_step (
    .cur      (cur),
    .nxt      (nxt),
    .val      (val),
    .k        (k),
    .next_cur (step_cur),
    .next_nxt (step_nxt),
    .stop     (step_stop)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_SEARCH;
      ST_SEARCH: if (step_stop) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the
  // state they describe without a decode after the flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      index_out <= '0;
      fib_out   <= '0;
      exact     <= 1'b0;
      val       <= '0;
      k         <= '0;
      cur       <= '0;
      nxt       <= '0;
    end else begin
      busy <= (state_next != ST_IDLE);
      done <= (state_next == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            val <= value_in;
            k   <= '0;
            cur <= '0;
            nxt <= (WIDTH+1)'(1);
          end
        end
        ST_SEARCH: begin
          if (step_stop) begin
            index_out <= k;
            fib_out   <= cur;
            exact     <= (cur == val);
          end else begin
            cur <= step_cur;
            nxt <= step_nxt;
            k   <= k + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_index_finder.sv
// tb/tb_fib_index_finder.sv - self-checking bench for fib_index_finder
module tb_fib_index_finder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] value_in;
  logic        busy;
  logic        done;
  logic [4:0]  index_out;
  logic [15:0] fib_out;
  logic        exact;

  int tests = 0;
  int fails = 0;

  fib_index_finder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .value_in  (value_in),
    .busy      (busy),
    .done      (done),
    .index_out (index_out),
    .fib_out   (fib_out),
    .exact     (exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: table of Fibonacci terms, pick the largest n <= 24 whose term fits.
  function automatic int fib_of(input int n);
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic void fib_model(input int v, output int idx, output int f, output int ex);
    idx = 0;
    for (int n = 0; n <= 24; n++)
      if (fib_of(n) <= v) idx = n;
    f  = fib_of(idx);
    ex = (f == v) ? 1 : 0;
  endfunction

  // Timeline model: accepted start at edge ending cycle t -> busy t+1..t+lat,
  // done at t+lat with lat = index+2; starts are only taken when idle.
  int cyc = 0;
  int acc = 0;
  int lat = 0;
  bit active = 0;
  int pend_idx, pend_fib, pend_ex;
  int shown_idx = 0, shown_fib = 0, shown_ex = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active = 0;
    end else begin
      bit idle;
      idle = !active || ((cyc - acc + 1) > lat);
      cyc++;
      if (idle && start) begin
        acc = cyc;
        fib_model(int'(value_in), pend_idx, pend_fib, pend_ex);
        lat = pend_idx + 2;
        active = 1;
      end
    end
  end

  always @(negedge clk) begin
    int d;
    bit exp_b, exp_d;
    exp_b = 0;
    exp_d = 0;
    if (!reset) begin
      shown_idx = 0;
      shown_fib = 0;
      shown_ex  = 0;
    end else if (active) begin
      d = cyc - acc + 1;
      exp_b = (d >= 1) && (d <= lat);
      exp_d = (d == lat);
      if (d == lat) begin
        shown_idx = pend_idx;
        shown_fib = pend_fib;
        shown_ex  = pend_ex;
      end
    end
    check("cyc busy", busy, exp_b);
    check("cyc done", done, exp_d);
    check("cyc index_out", index_out, shown_idx);
    check("cyc fib_out", fib_out, shown_fib);
    check("cyc exact", exact, shown_ex);
  end

  // Start one search; optionally pulse a second start (value 5) at cycle t+inj.
  task automatic run(input int v, input int e_idx, input int e_fib, input int e_ex,
                     input int e_lat, input int inj);
    int n;
    @(negedge clk);
    start = 1'b1;
    value_in = 16'(v);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      if (inj >= 2 && n == inj) begin
        start = 1'b1;
        value_in = 16'd5;
      end else if (inj >= 2 && n == inj + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check($sformatf("latency v=%0d", v), n, e_lat);
    check($sformatf("index v=%0d", v), index_out, e_idx);
    check($sformatf("fib v=%0d", v), fib_out, e_fib);
    check($sformatf("exact v=%0d", v), exact, e_ex);
  endtask

  initial begin
    int mi, mf, me, cnt;
    reset = 1'b0;
    start = 1'b0;
    value_in = '0;

    fib_model(100, mi, mf, me);
    check("model idx 100", mi, 11);
    check("model fib 100", mf, 89);
    fib_model(1, mi, mf, me);
    check("model idx 1", mi, 2);
    fib_model(65535, mi, mf, me);
    check("model idx 65535", mi, 24);
    check("model fib 65535", mf, 46368);
    check("model exact 65535", me, 0);

    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset index", index_out, 0);
    check("reset fib", fib_out, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run(0, 0, 0, 1, 2, 0);
    run(1, 2, 1, 1, 4, 0);
    run(100, 11, 89, 0, 13, 0);
    run(144, 12, 144, 1, 14, 0);
    run(2, 3, 2, 1, 5, 0);
    run(46368, 24, 46368, 1, 26, 0);
    run(65535, 24, 46368, 0, 26, 0);

    run(100, 11, 89, 0, 13, 3);
    // Start raised in the DONE cycle must be dropped.
    start = 1'b1;
    value_in = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("done-cycle start busy", busy, 0);
    check("done-cycle start index", index_out, 11);

    // Reset in the middle of a search.
    @(negedge clk);
    start = 1'b1;
    value_in = 16'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async rst busy", busy, 0);
    check("async rst index", index_out, 0);
    check("async rst fib", fib_out, 0);
    check("async rst exact", exact, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("no done after reset", cnt, 0);

    run(8, 6, 8, 1, 8, 0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
